// File: rtl/breakout_pkg.sv
// Shared definitions for the Breakout block column: coordinate type, side indices,
// screen extents, contact FSM states and a small range helper.
package breakout_pkg;

    localparam int COORD_W  = 11;
    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;

    // Bit positions inside a {U,D,L,R} contact/bounce vector.
    localparam int SIDE_R = 0;
    localparam int SIDE_L = 1;
    localparam int SIDE_D = 2;
    localparam int SIDE_U = 3;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIT,
        ST_WAIT_CLEAR
    } col_state_t;

    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/breakout_block_cell.sv
// One block of the column: hit counter, alive flag, registered contact flags and pixel test.
// Optional blink-on-damage behaviour is enabled by BLK_DAMAGE_FLASH_EN.
module breakout_block_cell
    import breakout_pkg::*;
#(
    parameter int ROW_IDX        = 0,
    parameter int COL_X_L        = 57,
    parameter int COL_X_R        = 72,
    parameter int ROW_Y0         = 4,
    parameter int ROW_PITCH      = 74,
    parameter int ROW_H          = 72,
    parameter int EDGE_DEPTH     = 3,
    parameter int HITS_PER_BLOCK = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  coord_t     i_pix_x,
    input  coord_t     i_pix_y,
    input  coord_t     i_ball_x_l,
    input  coord_t     i_ball_x_r,
    input  coord_t     i_ball_y_t,
    input  coord_t     i_ball_y_b,
    input  logic       i_hit,
    output logic       o_on,
    output logic [3:0] o_flags,
    output logic       o_dies
`ifdef BLK_DAMAGE_FLASH_EN
    ,
    output logic       o_dmg
`endif
);

    localparam coord_t X_L = coord_t'(COL_X_L);
    localparam coord_t X_R = coord_t'(COL_X_R);
    localparam coord_t TOP = coord_t'(ROW_Y0 + ROW_IDX * ROW_PITCH);
    localparam coord_t BOT = coord_t'(ROW_Y0 + ROW_IDX * ROW_PITCH + ROW_H);
    localparam coord_t DEP = coord_t'(EDGE_DEPTH);
    localparam coord_t SCR_W = coord_t'(SCREEN_W);
    localparam coord_t SCR_H = coord_t'(SCREEN_H);
    localparam logic [2:0] HITS_INIT = 3'(HITS_PER_BLOCK);

    logic [2:0] r_hits;
    logic [3:0] r_flags;
    logic [3:0] w_contact;
    logic       w_alive;
    logic       w_v_ovl;
    logic       w_h_ovl;
    logic       w_pix_in;

    assign w_alive  = (r_hits != 3'd0);
    assign w_v_ovl  = (i_ball_y_b >= TOP) && (i_ball_y_t <= BOT);
    assign w_h_ovl  = (i_ball_x_r >= X_L) && (i_ball_x_l <= X_R);
    assign w_pix_in = in_range(i_pix_x, X_L, X_R) && in_range(i_pix_y, TOP, BOT)
                      && (i_pix_x < SCR_W) && (i_pix_y < SCR_H);

    always_comb begin
        // NOTE: default first so every path assigns w_contact and no latch is inferred.
        w_contact = '0;
        if (w_alive) begin
            w_contact[SIDE_R] = in_range(i_ball_x_l, X_R - DEP, X_R) && w_v_ovl;
            w_contact[SIDE_L] = in_range(i_ball_x_r, X_L, X_L + DEP) && w_v_ovl;
            w_contact[SIDE_D] = in_range(i_ball_y_t, BOT - DEP, BOT) && w_h_ovl;
            w_contact[SIDE_U] = in_range(i_ball_y_b, TOP, TOP + DEP) && w_h_ovl;
        end
    end

    // NOTE: synchronous reset is simply the highest-priority branch of the clocked block.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hits  <= HITS_INIT;
            r_flags <= '0;
        end else begin
            r_flags <= w_contact;
            if (i_hit && w_alive) begin
                r_hits <= r_hits - 3'd1;
            end
        end
    end

    assign o_flags = r_flags;
    assign o_dies  = i_hit && (r_hits == 3'd1);

`ifdef BLK_DAMAGE_FLASH_EN
    logic [19:0] r_flash;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flash <= '0;
        end else if (i_hit && (r_hits > 3'd1)) begin
            r_flash <= '1;
        end else if (r_flash != '0) begin
            r_flash <= r_flash - 20'd1;
        end
    end

    // A damaged block blinks at bit-17 rate until its flash counter drains.
    assign o_on  = w_pix_in && w_alive && ((r_flash == '0) || r_flash[17]);
    assign o_dmg = (r_hits < HITS_INIT);
`else
    assign o_on = w_pix_in && w_alive;
`endif

endmodule

// File: rtl/breakout_block_column.sv
// Column of ROWS breakable blocks: lowest-row arbitration, one-hit-per-contact FSM,
// saturating score and live-block count. Optional macro: BLK_DAMAGE_FLASH_EN (adds dmg_mask).
module breakout_block_column
    import breakout_pkg::*;
#(
    parameter int ROWS           = 8,
    parameter int COL_X_L        = 57,
    parameter int COL_X_R        = 72,
    parameter int ROW_Y0         = 4,
    parameter int ROW_PITCH      = 74,
    parameter int ROW_H          = 72,
    parameter int EDGE_DEPTH     = 3,
    parameter int HITS_PER_BLOCK = 1,
    parameter int POINTS         = 5,
    parameter int SCORE_W        = 8,
    parameter int CLEAR_TIMEOUT  = 255,
    localparam int BL_W          = $clog2(ROWS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  coord_t             pix_x,
    input  coord_t             pix_y,
    input  coord_t             ball_x_l,
    input  coord_t             ball_x_r,
    input  coord_t             ball_y_t,
    input  coord_t             ball_y_b,
    output logic               col_on,
    output logic               move_u,
    output logic               move_d,
    output logic               move_l,
    output logic               move_r,
    output logic [SCORE_W-1:0] score,
    output logic [BL_W-1:0]    blocks_left,
    output logic               col_clear
`ifdef BLK_DAMAGE_FLASH_EN
    ,
    output logic [ROWS-1:0]    dmg_mask
`endif
);

    localparam int TO_W = $clog2(CLEAR_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(CLEAR_TIMEOUT - 1);
    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

    col_state_t         r_state;
    col_state_t         w_state_next;
    logic [TO_W-1:0]    r_wait_cnt;
    logic [3:0]         r_move;
    logic [SCORE_W-1:0] r_score;
    logic [BL_W-1:0]    r_blocks_left;
    logic               r_col_clear;

    logic [3:0]         w_flags [ROWS];
    logic [ROWS-1:0]    w_on;
    logic [ROWS-1:0]    w_dies;
    logic [ROWS-1:0]    w_win_onehot;
    logic [3:0]         w_win_flags;
    logic               w_any_contact;
    logic               w_take;
    logic               w_dies_any;
    logic [31:0]        w_score_sum;

    genvar g;
    for (g = 0; g < ROWS; g++) begin : g_row
        breakout_block_cell #(
            .ROW_IDX        (g),
            .COL_X_L        (COL_X_L),
            .COL_X_R        (COL_X_R),
            .ROW_Y0         (ROW_Y0),
            .ROW_PITCH      (ROW_PITCH),
            .ROW_H          (ROW_H),
            .EDGE_DEPTH     (EDGE_DEPTH),
            .HITS_PER_BLOCK (HITS_PER_BLOCK)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .i_pix_x    (pix_x),
            .i_pix_y    (pix_y),
            .i_ball_x_l (ball_x_l),
            .i_ball_x_r (ball_x_r),
            .i_ball_y_t (ball_y_t),
            .i_ball_y_b (ball_y_b),
            .i_hit      (w_take && w_win_onehot[g]),
            .o_on       (w_on[g]),
            .o_flags    (w_flags[g]),
            .o_dies     (w_dies[g])
`ifdef BLK_DAMAGE_FLASH_EN
            ,
            .o_dmg      (dmg_mask[g])
`endif
        );
    end

    // Lowest-index row with any contact flag wins; its flags alone drive the bounce.
    always_comb begin
        w_win_onehot  = '0;
        w_win_flags   = '0;
        w_any_contact = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            if (!w_any_contact && (w_flags[i] != 4'd0)) begin
                w_win_onehot[i] = 1'b1;
                w_win_flags     = w_flags[i];
                w_any_contact   = 1'b1;
            end
        end
    end

    assign w_take      = (r_state == ST_IDLE) && w_any_contact;
    assign w_dies_any  = |w_dies;
    assign w_score_sum = 32'(r_score) + 32'(POINTS);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_any_contact) w_state_next = ST_HIT;
            ST_HIT:        w_state_next = ST_WAIT_CLEAR;
            ST_WAIT_CLEAR: if (!w_any_contact || (r_wait_cnt == TO_LAST)) w_state_next = ST_IDLE;
            default:       w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_move        <= '0;
            r_score       <= '0;
            r_blocks_left <= BL_W'(ROWS);
            r_col_clear   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= (r_state == ST_WAIT_CLEAR) ? r_wait_cnt + 1'b1 : '0;
            r_move      <= w_take ? w_win_flags : 4'd0;
            r_col_clear <= (r_blocks_left == '0);
            if (w_dies_any) begin
                r_blocks_left <= r_blocks_left - 1'b1;
                r_score       <= (w_score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX)
                                                           : SCORE_W'(w_score_sum);
            end
        end
    end

    assign col_on      = |w_on;
    assign move_u      = r_move[SIDE_U];
    assign move_d      = r_move[SIDE_D];
    assign move_l      = r_move[SIDE_L];
    assign move_r      = r_move[SIDE_R];
    assign score       = r_score;
    assign blocks_left = r_blocks_left;
    assign col_clear   = r_col_clear;

endmodule

// File: tb/tb_breakout_block_column.sv
// Directed bench for breakout_block_column: three instances (defaults, two-hit blocks,
// 40-point blocks) driven by hand-computed contact vectors.
module tb_breakout_block_column;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst   [NDUT];
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic [10:0] bxl   [NDUT];
    logic [10:0] bxr   [NDUT];
    logic [10:0] byt   [NDUT];
    logic [10:0] byb   [NDUT];
    logic        con   [NDUT];
    logic        mu    [NDUT];
    logic        md    [NDUT];
    logic        ml    [NDUT];
    logic        mr    [NDUT];
    logic [7:0]  score [NDUT];
    logic [3:0]  bleft [NDUT];
    logic        cclr  [NDUT];
`ifdef BLK_DAMAGE_FLASH_EN
    logic [7:0]  dmg   [NDUT];
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < NDUT; g++) begin : g_dut
        breakout_block_column #(
            .HITS_PER_BLOCK ((g == 1) ? 2 : 1),
            .POINTS         ((g == 2) ? 40 : 5)
        ) u_dut (
            .clk         (clk),
            .reset       (rst[g]),
            .pix_x       (pix_x),
            .pix_y       (pix_y),
            .ball_x_l    (bxl[g]),
            .ball_x_r    (bxr[g]),
            .ball_y_t    (byt[g]),
            .ball_y_b    (byb[g]),
            .col_on      (con[g]),
            .move_u      (mu[g]),
            .move_d      (md[g]),
            .move_l      (ml[g]),
            .move_r      (mr[g]),
            .score       (score[g]),
            .blocks_left (bleft[g]),
            .col_clear   (cclr[g])
`ifdef BLK_DAMAGE_FLASH_EN
            ,
            .dmg_mask    (dmg[g])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ball(input int d, input int xl, input int xr, input int yt, input int yb);
        bxl[d] = 11'(xl);
        bxr[d] = 11'(xr);
        byt[d] = 11'(yt);
        byb[d] = 11'(yb);
    endtask

    task automatic park(input int d);
        set_ball(d, 200, 207, 300, 307);
    endtask

    task automatic probe(input int x, input int y);
        pix_x = 11'(x);
        pix_y = 11'(y);
        #1;
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        tick();
        rst[d] = 1'b0;
    endtask

    // Right-face contact on one row, held until the pulse, then cleared.
    task automatic destroy(input int d, input int row);
        int top;
        top = 4 + row * 74;
        set_ball(d, 70, 77, top + 10, top + 17);
        tick();
        tick();
        check($sformatf("destroy_d%0d_r%0d_move_r", d, row), 32'(mr[d]), 1);
        park(d);
        repeat (3) tick();
    endtask

    initial begin
        int cnt_a;
        int cnt_b;

        for (int i = 0; i < NDUT; i++) begin
            rst[i] = 1'b1;
            park(i);
        end
        pix_x = 11'd64;
        pix_y = 11'd40;
        repeat (2) tick();
        for (int i = 0; i < NDUT; i++) rst[i] = 1'b0;
        tick();

        // Reset state
        probe(64, 40);
        check("rst_col_on", 32'(con[0]), 1);
        check("rst_score", 32'(score[0]), 0);
        check("rst_blocks_left", 32'(bleft[0]), 8);
        check("rst_col_clear", 32'(cclr[0]), 0);
        check("rst_moves", 32'({mu[0], md[0], ml[0], mr[0]}), 0);

        // Held right-face contact on row 0: one pulse only
        set_ball(0, 70, 77, 10, 17);
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (c == 1) check("hold_c1_move_r", 32'(mr[0]), 0);
            if (c == 2) check("hold_c2_move_r", 32'(mr[0]), 1);
            cnt_a += int'(mr[0]);
            cnt_b += int'(mu[0]) + int'(md[0]) + int'(ml[0]);
        end
        check("hold_move_r_count", 32'(cnt_a), 1);
        check("hold_other_count", 32'(cnt_b), 0);
        check("hold_score", 32'(score[0]), 5);
        check("hold_blocks_left", 32'(bleft[0]), 7);
        probe(64, 40);
        check("hold_row0_off", 32'(con[0]), 0);
        probe(64, 100);
        check("hold_row1_on", 32'(con[0]), 1);
        park(0);
        repeat (3) tick();

        // Ball touching row1 bottom and row2 top: row1 wins
        do_reset(0);
        set_ball(0, 60, 67, 148, 153);
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) check("arb_c2_move_d", 32'(md[0]), 1);
            cnt_a += int'(md[0]);
            cnt_b += int'(mu[0]) + int'(ml[0]) + int'(mr[0]);
        end
        park(0);
        repeat (3) tick();
        check("arb_move_d_count", 32'(cnt_a), 1);
        check("arb_other_count", 32'(cnt_b), 0);
        check("arb_score", 32'(score[0]), 5);
        check("arb_blocks_left", 32'(bleft[0]), 7);
        probe(64, 180);
        check("arb_row2_on", 32'(con[0]), 1);
        probe(64, 100);
        check("arb_row1_off", 32'(con[0]), 0);

        // Clear the whole column
        do_reset(0);
        for (int r = 0; r < 8; r++) destroy(0, r);
        check("clear_score", 32'(score[0]), 40);
        check("clear_blocks_left", 32'(bleft[0]), 0);
        check("clear_col_clear", 32'(cclr[0]), 1);
        probe(64, 40);
        check("clear_row0_off", 32'(con[0]), 0);
        set_ball(0, 70, 77, 10, 17);
        cnt_a = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            cnt_a += int'(mu[0]) + int'(md[0]) + int'(ml[0]) + int'(mr[0]);
        end
        check("clear_no_pulses", 32'(cnt_a), 0);
        park(0);
        tick();

        // Reset during WAIT_CLEAR, contact still present
        do_reset(0);
        set_ball(0, 70, 77, 10, 17);
        tick();
        tick();
        check("wrst_first_move_r", 32'(mr[0]), 1);
        tick();
        do_reset(0);
        check("wrst_score", 32'(score[0]), 0);
        check("wrst_blocks_left", 32'(bleft[0]), 8);
        check("wrst_moves", 32'({mu[0], md[0], ml[0], mr[0]}), 0);
        probe(64, 40);
        check("wrst_row0_on", 32'(con[0]), 1);
        tick();
        check("wrst_c1_move_r", 32'(mr[0]), 0);
        tick();
        check("wrst_c2_move_r", 32'(mr[0]), 1);
        check("wrst_rehit_score", 32'(score[0]), 5);
        park(0);
        repeat (3) tick();

        // Two-hit blocks: top contact on row1 twice
        set_ball(1, 60, 67, 72, 79);
        tick();
        tick();
        check("h2_first_move_u", 32'(mu[1]), 1);
        park(1);
        repeat (3) tick();
        check("h2_first_score", 32'(score[1]), 0);
        check("h2_first_blocks_left", 32'(bleft[1]), 8);
        probe(64, 100);
        check("h2_first_row1_on", 32'(con[1]), 1);
        set_ball(1, 60, 67, 72, 79);
        tick();
        tick();
        check("h2_second_move_u", 32'(mu[1]), 1);
        park(1);
        repeat (3) tick();
        check("h2_second_score", 32'(score[1]), 5);
        check("h2_second_blocks_left", 32'(bleft[1]), 7);
        probe(64, 100);
        check("h2_second_row1_off", 32'(con[1]), 0);

        // 40-point blocks: score saturates at 255
        for (int r = 0; r < 6; r++) destroy(2, r);
        check("sat_score_6", 32'(score[2]), 240);
        destroy(2, 6);
        check("sat_score_7", 32'(score[2]), 255);
        destroy(2, 7);
        check("sat_score_8", 32'(score[2]), 255);
        check("sat_blocks_left", 32'(bleft[2]), 0);
        check("sat_col_clear", 32'(cclr[2]), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
